// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, ack-based release
// and a timeout that reclaims a grant the consumer never acknowledges.
module rr_arbiter_8 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic       ack_in,
    output logic [7:0] grant_out,
    output logic       grant_valid,
    output logic       timeout_err,
    output logic       state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gidx_q, gidx_d;

    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    // Circular search starting one past the last granted index; k = 8 wraps to ptr itself.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!pick_found && req_in[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gidx_d  = pick_idx;
                    grant_d = 8'd1 << pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                // Ack is checked first so it wins over a simultaneous expiry.
                if (ack_in) begin
                    state_d = IDLE;
                    grant_d = 8'd0;
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    ptr_d   = gidx_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    grant_d = 8'd0;
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    ptr_d   = gidx_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'd0;
                valid_d = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            ptr_q   <= 3'd7;
            gidx_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

    assign grant_out   = grant_q;
    assign grant_valid = valid_q;
    assign timeout_err = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of grant ownership and grant age.
module tb_rr_arbiter_8;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_in = 8'd0;
    logic       ack_in = 1'b0;
    logic [7:0] grant_out;
    logic       grant_valid;
    logic       timeout_err;
    logic       state_dbg;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .ack_in      (ack_in),
        .grant_out   (grant_out),
        .grant_valid (grant_valid),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: owner index (-1 = nobody), last owner, cycles the grant has been visible.
    int m_idx = -1;
    int m_ptr = 7;
    int m_age = 0;
    bit m_err = 1'b0;

    logic [7:0] seen_q[$];
    logic [7:0] exp_q[$];

    function automatic void model_edge(bit r, logic [7:0] rq, bit a);
        int cand;
        if (!r) begin
            m_idx = -1;
            m_ptr = 7;
            m_age = 0;
            m_err = 1'b0;
        end else if (m_idx < 0) begin
            m_err = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                cand = (m_ptr + k) % 8;
                if (m_idx < 0 && rq[cand]) m_idx = cand;
            end
            if (m_idx >= 0) m_age = 1;
        end else if (a) begin
            m_ptr = m_idx;
            m_idx = -1;
            m_err = 1'b0;
        end else if (m_age == TO) begin
            m_ptr = m_idx;
            m_idx = -1;
            m_err = 1'b1;
        end else begin
            m_age = m_age + 1;
            m_err = 1'b0;
        end
    endfunction

    task automatic check(input string tag);
        logic [7:0] exp_g;
        logic       exp_v;
        exp_g = (m_idx < 0) ? 8'd0 : 8'(1 << m_idx);
        exp_v = (m_idx >= 0);
        vectors++;
        assert (grant_out === exp_g) else begin
            miscompares++;
            $error("FAIL %s grant_out got %h expected %h", tag, grant_out, exp_g);
        end
        vectors++;
        assert (grant_valid === exp_v) else begin
            miscompares++;
            $error("FAIL %s grant_valid got %b expected %b", tag, grant_valid, exp_v);
        end
        vectors++;
        assert (timeout_err === m_err) else begin
            miscompares++;
            $error("FAIL %s timeout_err got %b expected %b", tag, timeout_err, m_err);
        end
    endtask

    task automatic step(input bit r, input logic [7:0] rq, input bit a, input string tag);
        @(negedge clk);
        rst_n  = r;
        req_in = rq;
        ack_in = a;
        model_edge(r, rq, a);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic direct(input string tag, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        int vcnt;
        int ecnt;
        logic [7:0] rq;

        // Reset
        step(1'b0, 8'h00, 1'b0, "reset");
        step(1'b0, 8'hFF, 1'b1, "reset_hold");
        step(1'b1, 8'h00, 1'b1, "idle_ack_ignored");

        // Scenario 1: single requester, ack in third grant cycle, re-grant after one idle cycle
        step(1'b1, 8'h01, 1'b0, "s1_grant");
        direct("s1_first_grant", grant_out, 8'h01);
        step(1'b1, 8'h01, 1'b0, "s1_hold2");
        step(1'b1, 8'h01, 1'b0, "s1_hold3");
        step(1'b1, 8'h01, 1'b1, "s1_ack");
        direct("s1_cleared", grant_out, 8'h00);
        step(1'b1, 8'h01, 1'b0, "s1_regrant");
        direct("s1_regrant_val", grant_out, 8'h01);

        // Scenario 2: fairness with all requests held and ack every cycle
        step(1'b0, 8'h00, 1'b0, "s2_reset");
        seen_q.delete();
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 8'hFF, 1'b1, "s2_rr");
            if (grant_valid) seen_q.push_back(grant_out);
        end
        exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        direct("s2_grant_count", 8'(seen_q.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
            direct("s2_sequence", seen_q[i], exp_q[i]);

        // Scenario 3: wrap-around from ptr = 5
        step(1'b0, 8'h00, 1'b0, "s3_reset");
        step(1'b1, 8'h20, 1'b0, "s3_g20");
        step(1'b1, 8'h20, 1'b1, "s3_ack20");
        step(1'b1, 8'h21, 1'b0, "s3_wrap");
        direct("s3_wrap_grant", grant_out, 8'h01);
        step(1'b1, 8'h21, 1'b1, "s3_ack01");
        step(1'b1, 8'h21, 1'b0, "s3_next");
        direct("s3_next_grant", grant_out, 8'h20);

        // Scenario 4: timeout with no ack, next search starts from index 4
        step(1'b0, 8'h00, 1'b0, "s4_reset");
        vcnt = 0;
        ecnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'h08, 1'b0, "s4_wait");
            if (grant_valid) vcnt++;
            if (timeout_err) ecnt++;
        end
        direct("s4_valid_cycles", 8'(vcnt), 8'(TO));
        direct("s4_err_pulses", 8'(ecnt), 8'd1);
        step(1'b1, 8'h18, 1'b0, "s4_after");
        direct("s4_search_from_4", grant_out, 8'h10);
        direct("s4_err_cleared", {7'd0, timeout_err}, 8'd0);

        // Scenario 5: ack on the last permitted cycle wins over timeout
        step(1'b0, 8'h00, 1'b0, "s5_reset");
        step(1'b1, 8'h02, 1'b0, "s5_grant");
        for (int i = 2; i <= 15; i++) step(1'b1, 8'h02, 1'b0, "s5_hold");
        step(1'b1, 8'h02, 1'b1, "s5_ack_last");
        direct("s5_no_err", {7'd0, timeout_err}, 8'd0);
        direct("s5_released", {7'd0, grant_valid}, 8'd0);

        // Scenario 6: reset mid-grant
        step(1'b0, 8'h00, 1'b0, "s6_reset");
        step(1'b1, 8'h80, 1'b0, "s6_grant");
        step(1'b1, 8'h80, 1'b0, "s6_hold");
        step(1'b0, 8'h80, 1'b0, "s6_midreset");
        direct("s6_grant_dropped", grant_out, 8'h00);
        direct("s6_no_err", {7'd0, timeout_err}, 8'd0);
        step(1'b1, 8'h81, 1'b0, "s6_release_low");
        direct("s6_low_first", grant_out, 8'h01);
        step(1'b0, 8'h00, 1'b0, "s6_reset2");
        step(1'b1, 8'h80, 1'b0, "s6_release_only80");
        direct("s6_only80", grant_out, 8'h80);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rq = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 4) == 0) rq = 8'h00;
            step(($urandom_range(0, 79) != 0), rq, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles a grant is held without ack (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port req_in, input, 8 bits: level request lines; bit i is requester i.
REQ-005 The block SHALL have port ack_in, input, 1 bit: consumer acknowledge of the current grant.
REQ-006 The block SHALL have port grant_out, output, 8 bits, registered: one-hot grant, the data input of the downstream 8-to-3 encoder.
REQ-007 The block SHALL have port grant_valid, output, 1 bit, registered: high exactly while grant_out holds a one-hot grant.
REQ-008 The block SHALL have port timeout_err, output, 1 bit, registered: one-cycle pulse when a grant is dropped for lack of ack.

Function
REQ-009 The block SHALL implement two states, IDLE and GRANT.
REQ-010 In IDLE, grant_out SHALL be 8'b0 and grant_valid SHALL be 0.
REQ-011 In GRANT, grant_out SHALL have exactly one bit set and grant_valid SHALL be 1, so the encoder never sees all-zero or multi-hot input while grant_valid is high.
REQ-012 The block SHALL keep a 3-bit pointer ptr holding the index of the last granted requester.
REQ-013 IDLE -> GRANT transition: at a rising edge in IDLE with req_in != 0, the block SHALL load grant_out with the first set bit of req_in, searching circularly from index ptr+1 mod 8 upward; the result is visible the cycle after the request is sampled.
REQ-014 IDLE with req_in == 0: the block SHALL remain in IDLE, with ptr unchanged.
REQ-015 GRANT -> IDLE on ack: at a rising edge in GRANT with ack_in = 1, the block SHALL clear grant_out and grant_valid and set ptr to the granted index.
REQ-016 Minimum spacing: the block SHALL hold grant_out at 0 for at least one cycle between consecutive grants.
REQ-017 Request withdrawal: the grant SHALL be held unchanged in GRANT even if the granted req_in bit deasserts; only ack, timeout or reset end a grant.
REQ-018 Timeout counter: a counter SHALL be cleared on entry to GRANT and increment on each GRANT cycle without ack.
REQ-019 Timeout expiry: at the edge where the counter equals TIMEOUT-1 and ack_in = 0, the block SHALL return to IDLE, clear the grant, pulse timeout_err for exactly one cycle, and set ptr to the granted index.
REQ-020 A grant SHALL therefore last at most TIMEOUT cycles.
REQ-021 Simultaneous ack and timeout: ack SHALL win; timeout_err stays 0.
REQ-022 Fairness: with all eight requests held continuously, grants SHALL cycle through indices 0,1,...,7,0,... with no index skipped.
REQ-023 ack_in while in IDLE SHALL be ignored.

Reset
REQ-024 At a rising edge with rst_n = 0, the block SHALL enter IDLE and set grant_out = 8'b0, grant_valid = 0, timeout_err = 0, the counter to 0, and ptr = 3'd7, so index 0 has first priority.
REQ-025 Reset SHALL take priority over all other inputs, including mid-grant, where it drops the grant with no timeout_err.
REQ-026 The block SHALL sample requests on the first edge after rst_n returns to 1.

Verification
REQ-027 Scenario 1: after reset, req_in = 8'h01 held, ack_in pulsed on the 3rd cycle of the grant -> grant_out = 8'h01, grant_valid = 1 one cycle after request, cleared after ack, re-granted after one idle cycle.
REQ-028 Scenario 2: req_in = 8'hFF held, ack on every grant cycle -> grant sequence 01,02,04,08,10,20,40,80,01 with a 0 cycle between each.
REQ-029 Scenario 3: ptr = 5 (last grant 8'h20), req_in = 8'h21 -> next grant is 8'h01 (wrap-around), then 8'h20.
REQ-030 Scenario 4: TIMEOUT = 15, grant 8'h08 with no ack -> grant_valid high for exactly 15 cycles, then timeout_err = 1 for one cycle and the next grant searches from index 4.
REQ-031 Scenario 5: ack_in = 1 on the edge where the counter = 14 -> normal release with timeout_err = 0.
REQ-032 Scenario 6: rst_n = 0 asserted mid-grant with req_in = 8'h80 -> next cycle grant_out = 0 and timeout_err = 0; after release the first grant is 8'h80 only if no lower index is requesting.
